// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the memory arbiter: FSM encoding, requester
// indices and a helper that turns a grant vector into read-response bits.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } arb_state_e;

    // Bit positions of each requester in grant / rvalid vectors.
    localparam int unsigned REQ_FETCH = 0;
    localparam int unsigned REQ_LS    = 1;
    localparam int unsigned REQ_DMA   = 2;

    // A grant produces a read response unless it is a write; fetch is read only.
    function automatic logic [2:0] read_mask(input logic [2:0] gnt,
                                             input logic       ls_we,
                                             input logic       dma_we);
        logic [2:0] rd_s;
        rd_s            = 3'b000;
        rd_s[REQ_FETCH] = 1'b1;
        rd_s[REQ_LS]    = ~ls_we;
        rd_s[REQ_DMA]   = ~dma_we;
        return gnt & rd_s;
    endfunction

endpackage

// File: rtl/mem_arbiter_select.sv
// Priority select with fetch starvation override: ls > dma > fetch, but a
// fetch that has waited STARVE_MAX cycles wins over everything.
module arb_select
    import mem_arbiter_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       fetch_req,
    input  logic       fetch_en,
    input  logic       ls_req,
    input  logic       dma_req,
    output logic [2:0] gnt
);

    localparam int CNT_W = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    logic [CNT_W-1:0] starve_cnt_r;
    logic             fetch_ok_s;
    logic             starve_hit_s;

    // Pick one winner from current requests and the registered wait count.
    always_comb begin
        gnt          = 3'b000;
        fetch_ok_s   = fetch_req & fetch_en;
        starve_hit_s = fetch_ok_s & (starve_cnt_r == CNT_MAX);
        if (starve_hit_s) begin
            gnt[REQ_FETCH] = 1'b1;
        end else if (ls_req) begin
            gnt[REQ_LS] = 1'b1;
        end else if (dma_req) begin
            gnt[REQ_DMA] = 1'b1;
        end else if (fetch_ok_s) begin
            gnt[REQ_FETCH] = 1'b1;
        end else begin
            gnt = 3'b000;
        end
    end

    // Count cycles a fetch waits unserved; saturate, clear on service or idle.
    always_ff @(posedge clock) begin
        if (!reset) begin
            starve_cnt_r <= {CNT_W{1'b0}};
        end else if (fetch_req && !gnt[REQ_FETCH]) begin
            if (starve_cnt_r != CNT_MAX) begin
                starve_cnt_r <= starve_cnt_r + CNT_W'(1);
            end else begin
                starve_cnt_r <= starve_cnt_r;
            end
        end else begin
            starve_cnt_r <= {CNT_W{1'b0}};
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between instruction fetch, load/store and a
// DMA loader. Owns the halt FSM and the one-cycle read response tracking.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 16,
    parameter int STARVE_MAX = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              halt,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic              fetch_gnt,
    input  logic              ls_req,
    input  logic              ls_we,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [DATA_W-1:0] ls_wdata,
    output logic              ls_gnt,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic              dma_gnt,
    output logic [2:0]        rvalid,
    output logic [DATA_W-1:0] rdata,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              halted
);

    arb_state_e        state_r;
    arb_state_e        state_nxt_s;
    logic [2:0]        sel_gnt_s;
    logic [2:0]        gnt_s;
    logic [2:0]        rvalid_r;
    logic              fetch_en_s;
    logic [ADDR_W-1:0] addr_hold_r;
    logic [ADDR_W-1:0] sel_addr_s;

    // Fetch is only eligible while running and not in the cycle halt arrives.
    always_comb begin
        fetch_en_s = (state_r == ST_RUN) && !halt;
    end

    arb_select #(
        .STARVE_MAX (STARVE_MAX)
    ) u_sel (
        .clock     (clock),
        .reset     (reset),
        .fetch_req (fetch_req),
        .fetch_en  (fetch_en_s),
        .ls_req    (ls_req),
        .dma_req   (dma_req),
        .gnt       (sel_gnt_s)
    );

    // Suppress all grants while reset is held and route the winner to memory.
    always_comb begin
        gnt_s     = reset ? sel_gnt_s : 3'b000;
        mem_we    = 1'b0;
        mem_wdata = {DATA_W{1'b0}};
        sel_addr_s = addr_hold_r;
        case (gnt_s)
            3'b001: begin
                sel_addr_s = fetch_addr;
            end
            3'b010: begin
                mem_we     = ls_we;
                sel_addr_s = ls_addr;
                mem_wdata  = ls_wdata;
            end
            3'b100: begin
                mem_we     = dma_we;
                sel_addr_s = dma_addr;
                mem_wdata  = dma_wdata;
            end
            default: begin
                mem_we     = 1'b0;
                sel_addr_s = addr_hold_r;
            end
        endcase
        mem_addr  = sel_addr_s;
        fetch_gnt = gnt_s[REQ_FETCH];
        ls_gnt    = gnt_s[REQ_LS];
        dma_gnt   = gnt_s[REQ_DMA];
    end

    // Halt sequencing: stop fetch, let the last read response land, then park.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_RUN: begin
                if (halt) begin
                    state_nxt_s = ST_DRAIN;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (rvalid_r == 3'b000) begin
                    state_nxt_s = ST_HALTED;
                end else begin
                    state_nxt_s = ST_DRAIN;
                end
            end
            ST_HALTED: begin
                state_nxt_s = ST_HALTED;
            end
            default: begin
                state_nxt_s = ST_RUN;
            end
        endcase
    end

    // State, pending read response flags and last driven address.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_r     <= ST_RUN;
            rvalid_r    <= 3'b000;
            addr_hold_r <= {ADDR_W{1'b0}};
        end else begin
            state_r  <= state_nxt_s;
            rvalid_r <= read_mask(gnt_s, ls_we, dma_we);
            if (gnt_s != 3'b000) begin
                addr_hold_r <= sel_addr_s;
            end else begin
                addr_hold_r <= addr_hold_r;
            end
        end
    end

    // A response in flight when reset asserts is dropped immediately.
    always_comb begin
        rvalid = reset ? rvalid_r : 3'b000;
        rdata  = mem_rdata;
        halted = (state_r == ST_HALTED);
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, memory address width.
REQ-002 SHALL have parameter DATA_W, default 16, memory word width.
REQ-003 SHALL have parameter STARVE_MAX, default 4, fetch-wait cycles that force a fetch grant.
REQ-004 clock  in  1  single clock; all state updates on posedge.
REQ-005 reset  in  1  synchronous, active-low.
REQ-006 halt  in  1  HLT decoded; stop serving fetch.
REQ-007 fetch_req  in  1  instruction fetch request (read only).
REQ-008 fetch_addr  in  ADDR_W  PC address.
REQ-009 fetch_gnt  out  1  fetch access issued this cycle.
REQ-010 ls_req  in  1  LD/ST request.
REQ-011 ls_we  in  1  1 = store, 0 = load.
REQ-012 ls_addr  in  ADDR_W  ALU-computed data address.
REQ-013 ls_wdata  in  DATA_W  store data.
REQ-014 ls_gnt  out  1  LD/ST access issued this cycle.
REQ-015 dma_req  in  1  loader/debug request.
REQ-016 dma_we  in  1  loader write enable.
REQ-017 dma_addr  in  ADDR_W  loader address.
REQ-018 dma_wdata  in  DATA_W  loader write data.
REQ-019 dma_gnt  out  1  loader access issued this cycle.
REQ-020 rvalid  out  3  one-hot read-data valid {dma, ls, fetch}.
REQ-021 rdata  out  DATA_W  read data, passed through from mem_rdata.
REQ-022 mem_we / mem_addr / mem_wdata  out  1/ADDR_W/DATA_W  shared memory port.
REQ-023 mem_rdata  in  DATA_W  memory read data, valid one cycle after address.
REQ-024 halted  out  1  arbiter is in HALTED.

Function
REQ-025 SHALL issue at most one grant per cycle; each grant is combinational from the registered state and current requests.
REQ-026 Priority SHALL be ls > dma > fetch, except when starve_cnt == STARVE_MAX and fetch_req=1, in which case fetch SHALL win.
REQ-027 starve_cnt SHALL increment (saturating at STARVE_MAX) each cycle fetch_req=1 and fetch_gnt=0, and clear on fetch_gnt or fetch_req=0.
REQ-028 mem_addr/mem_we/mem_wdata SHALL reflect the granted requester in the grant cycle; with no grant, mem_we=0 and mem_addr holds its last value.
REQ-029 A read grant in cycle N SHALL assert the matching rvalid bit in cycle N+1 only; a write grant SHALL produce no rvalid.
REQ-030 Back-to-back grants SHALL be supported (one access per cycle, no bubbles).
REQ-031 Requesters SHALL hold req/addr/wdata until they sample their gnt high; the arbiter does not latch request fields.
REQ-032 FSM states: RUN, DRAIN, HALTED.
REQ-033 RUN -> DRAIN when halt=1; in DRAIN and HALTED, fetch_gnt SHALL be 0 while ls/dma are still served.
REQ-034 DRAIN -> HALTED once no read response is outstanding (next cycle if none); halted=1 only in HALTED.
REQ-035 HALTED -> RUN only on reset; halt deasserting SHALL NOT leave HALTED.
REQ-036 halt and a fetch request in the same cycle: fetch SHALL NOT be granted.

Reset
REQ-037 With reset=0 at posedge: state=RUN, starve_cnt=0, rvalid=0, mem_addr=0, halted=0; all gnt and mem_we SHALL be 0 while reset=0.
REQ-038 Reset during an outstanding read SHALL discard that response (no rvalid after reset).

Structure
REQ-039 FSM state encoding and requester index constants (FETCH=0, LS=1, DMA=2) SHALL live in the shared package.
REQ-040 The priority/starvation select SHALL be one sub-module, arb_select; the FSM and response tracking stay in mem_arbiter.

Verification
REQ-041 fetch_req=1 alone, fetch_addr=0x10, mem_rdata=0x1234 -> fetch_gnt same cycle, rvalid=3'b001 and rdata=0x1234 next cycle.
REQ-042 ls_req (store 0x20, 0xBEEF), dma_req and fetch_req together -> ls_gnt, mem_we=1, mem_addr=0x20; no rvalid next cycle.
REQ-043 ls_req held high with fetch_req for 6 cycles, STARVE_MAX=4 -> fetch_gnt in cycle 5, starve_cnt then 0.
REQ-044 Load granted, then halt=1 next cycle -> DRAIN, rvalid=3'b010 delivered, HALTED the following cycle; later fetch_req never granted and dma still granted.
REQ-045 Read granted then reset=0 next cycle -> rvalid stays 0, state RUN, all gnts 0.
